mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one inferred 32-bit single-port synchronous-read RAM between two requesters.
//   - Port A: instruction fetch, read-only.
//   - Port B: load/store, RV32 funct3 sizes.
// - Round-robin arbitration; at most one RAM access per cycle.
// - Store byte-lane masking and load sign/zero extension live here, so the RAM stays a plain read-first array.
// - Sits between the core pipeline and the memory array; closes timing on sysMEM (DP16KD).
// PARAMETERS
// - ADDR_W   13   word-address width; RAM depth = 2**ADDR_W words of 32 bits
// - FIRST_B  0    round-robin pointer value after reset (0: A wins the first tie, 1: B wins)
// PORTS
// - clock        in   1   rising-edge clock, sole clock domain
// - reset_n      in   1   asynchronous active-low reset
// - a_valid      in   1   port A fetch request
// - a_ready      out  1   port A request accepted this cycle
// - a_addr       in   32  port A byte address (bits [1:0] ignored)
// - a_rsp_valid  out  1   port A response slot full
// - a_rsp_ready  in  1   port A consumer takes response
// - a_rsp_data   out  32  fetched word
// - b_valid      in   1   port B request
// - b_ready      out  1   port B request accepted this cycle
// - b_write      in   1   1 = store, 0 = load
// - b_funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); low 2 bits give size for stores
// - b_addr       in   32  port B byte address
// - b_wdata      in   32  store data, LSB-aligned
// - b_rsp_valid  out  1   port B response slot full (loads and stores both respond)
// - b_rsp_ready  in   1   port B consumer takes response
// - b_rsp_data   out  32  extended load data; 0 for stores
// - b_rsp_err    out  1   misaligned access flag (MEM_ARB_MISALIGN_EN only, else 0)
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - All *_rsp_valid, *_rsp_data, b_rsp_err = 0.
//   - rr pointer = FIRST_B.
//   - RAM contents undefined / unchanged.
// - Port eligibility: a port is eligible when valid=1 and its response slot is EMPTY, or FULL with rsp_ready=1 this cycle.
// - Grant: only eligible ports can win.
//   - One eligible port wins outright.
//   - Both eligible: the port named by rr wins; rr then flips to the loser.
//   - rr is unchanged when only one port requests.
//   - ready is asserted combinationally for the winner only.
// - Word index = addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2**ADDR_W.
// - Latency: request accepted at edge N -> response slot FULL, data valid from edge N+1.
//   - Back-to-back grants to the same port are allowed when its response is consumed in the same cycle: 1 access/cycle sustained.
// - Response slot per port, two states:
//   - EMPTY -> FULL on grant.
//   - FULL -> EMPTY on rsp_ready without a new grant.
//   - FULL -> FULL (new data) on rsp_ready with a grant.
//   - Response data holds stable while FULL and rsp_ready=0.
// - Store write enables: we[3:0] = size mask << addr[1:0], where size mask is B 0001, H 0011, W 1111.
//   - wdata is replicated across lanes.
//   - Store is read-first; the response carries 0.
// - Load extraction:
//   - Byte lane addr[1:0] / half lane addr[1].
//   - B/H sign-extend; BU/HU zero-extend; W passes through.
//   - Extraction uses the address registered at the grant, not the live input.
// - Reserved funct3 (011, 11x): treated as W.
// - Same-word conflict cannot occur: there is only one access per cycle.
//   - A store at N followed by a load of the same word at N+1 returns the new data.
// - reset_n asserted mid-access: the in-flight response is discarded; the RAM write at that edge may or may not land.
// CONFIGURATION
// - MEM_ARB_MISALIGN_EN defined:
//   - Port B H/HU with addr[0]=1, or W with addr[1:0]!=0, is still granted.
//   - No RAM write occurs.
//   - Response is b_rsp_err=1, b_rsp_data=0.
//   - Port A with a_addr[1:0]!=0 is served normally, with the low bits ignored.
// - MEM_ARB_MISALIGN_EN undefined:
//   - b_rsp_err is tied 0.
//   - Misaligned H uses the masked lane (addr[1]); misaligned W ignores addr[1:0].
// TESTING
// 1. Reset, then a_valid at 0x10 only -> a_ready same cycle; next cycle a_rsp_valid=1 with the word at index 4; rr unchanged.
// 2. Both valid every cycle, rsp_ready=1, FIRST_B=0 -> grants alternate A,B,A,B; each port gets one response every 2 cycles.
// 3. SB 0xA5 to 0x103, then LB 0x103 -> 0xFFFFFFA5; LBU 0x103 -> 0x000000A5; the other three bytes of the word are unchanged.
// 4. a_rsp_ready=0 with A FULL and a_valid=1, B idle -> a_ready=0, a_rsp_data stable; raise a_rsp_ready -> grant in that same cycle.
// 5. SW 0xDEADBEEF at 0x8 at edge N, LW 0x8 at N+1 -> 0xDEADBEEF; with MEM_ARB_MISALIGN_EN, SW to 0xA -> b_rsp_err=1 and word 0x8 unchanged.
// 6. Pull reset_n low while b_rsp_valid=1 -> b_rsp_valid=0 immediately (async); after release, rr=FIRST_B.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, read-first, synchronous-read RAM
// between fetch port A and load/store port B. Define MEM_ARB_MISALIGN_EN to flag misaligned B accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter bit FIRST_B = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_addr,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    output logic [31:0] a_rsp_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_write,
    input  logic [2:0]  b_funct3,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [31:0] b_rsp_data,
    output logic        b_rsp_err
);
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic              a_elig, b_elig, grant_a, grant_b, rr;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        b_size, b_off;
    logic [3:0]        b_mask, we;
    logic [31:0]       b_wword;
    logic              b_mis;

    logic              a_fresh, b_fresh;
    logic [31:0]       a_hold, b_hold, b_raw, b_shift;
    logic [1:0]        b_size_q, b_off_q;
    logic              b_uns_q, b_wr_q, b_err_q;

    logic              unused_bits;
    assign unused_bits = ^{a_addr[31:ADDR_W+2], a_addr[1:0], b_addr[31:ADDR_W+2], b_shift[31:16]};

    assign a_elig  = a_valid && (!a_rsp_valid || a_rsp_ready);
    assign b_elig  = b_valid && (!b_rsp_valid || b_rsp_ready);
    // rr names the port that wins a tie
    assign grant_a = a_elig && (!b_elig || !rr);
    assign grant_b = b_elig && (!a_elig || rr);
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign idx     = grant_b ? b_addr[ADDR_W+1:2] : a_addr[ADDR_W+1:2];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        b_size  = (b_funct3[1:0] == 2'b11) ? SZ_W : b_funct3[1:0];
        b_off   = 2'b00;
        b_mask  = 4'b1111;
        b_wword = b_wdata;
        case (b_size)
            SZ_B: begin
                b_off   = b_addr[1:0];
                b_mask  = 4'b0001;
                b_wword = {4{b_wdata[7:0]}};
            end
            SZ_H: begin
                b_off   = {b_addr[1], 1'b0};
                b_mask  = 4'b0011;
                b_wword = {2{b_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef MEM_ARB_MISALIGN_EN
        b_mis = ((b_size == SZ_H) && b_addr[0]) ||
                ((b_size == SZ_W) && (b_addr[1:0] != 2'b00));
`else
        b_mis = 1'b0;
`endif
        we = (grant_b && b_write && !b_mis) ? (b_mask << b_off) : 4'b0000;
    end

    // NOTE: the array and its read register carry no reset; clearing a RAM is not possible in one edge.
    always_ff @(posedge clock) begin
        if (grant_a || grant_b) begin
            ram_q <= mem[idx];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[idx][8*i +: 8] <= b_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr          <= FIRST_B;
            a_rsp_valid <= 1'b0;
            a_fresh     <= 1'b0;
            a_hold      <= 32'h0;
            b_rsp_valid <= 1'b0;
            b_fresh     <= 1'b0;
            b_hold      <= 32'h0;
            b_size_q    <= SZ_B;
            b_off_q     <= 2'b00;
            b_uns_q     <= 1'b0;
            b_wr_q      <= 1'b0;
            b_err_q     <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            if (a_elig && b_elig) rr <= grant_a;
            if (grant_a)          a_rsp_valid <= 1'b1;
            else if (a_rsp_ready) a_rsp_valid <= 1'b0;
            if (grant_b)          b_rsp_valid <= 1'b1;
            else if (b_rsp_ready) b_rsp_valid <= 1'b0;
            // ram_q is shared, so each port snapshots its word once the next access may overwrite it
            a_fresh <= grant_a;
            b_fresh <= grant_b;
            if (a_fresh) a_hold <= ram_q;
            if (b_fresh) b_hold <= ram_q;
            if (grant_b) begin
                b_size_q <= b_size;
                b_off_q  <= b_off;
                b_uns_q  <= b_funct3[2];
                b_wr_q   <= b_write;
                b_err_q  <= b_mis;
            end
        end
    end

    assign a_rsp_data = a_fresh ? ram_q : a_hold;
    assign b_raw      = b_fresh ? ram_q : b_hold;
    assign b_shift    = b_raw >> {b_off_q, 3'b000};
    assign b_rsp_err  = b_err_q;

    always_comb begin
        case (b_size_q)
            SZ_B:    b_rsp_data = b_uns_q ? {24'h0, b_shift[7:0]} : {{24{b_shift[7]}}, b_shift[7:0]};
            SZ_H:    b_rsp_data = b_uns_q ? {16'h0, b_shift[15:0]} : {{16{b_shift[15]}}, b_shift[15:0]};
            default: b_rsp_data = b_raw;
        endcase
        if (b_wr_q || b_err_q) b_rsp_data = 32'h0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// then randomized traffic against a byte-level reference model.
module tb_mem_port_arbiter;
    localparam bit FIRST_B = 1'b0;
    localparam int NV      = 20;
`ifdef MEM_ARB_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid, a_ready, a_rsp_valid, a_rsp_ready;
    logic [31:0] a_addr, a_rsp_data;
    logic        b_valid, b_ready, b_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [2:0]  b_funct3;
    logic [31:0] b_addr, b_wdata, b_rsp_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs [NV];

    // reference model state
    logic [31:0] m_mem [16];
    bit          m_a_full, m_b_full, m_rr_b, m_b_err;
    logic [31:0] m_a_data, m_b_data;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(13), .FIRST_B(FIRST_B)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_funct3(b_funct3),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err)
    );

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input int n, input logic [31:0] addr);
        if (n == 1) return int'(addr[1:0]);
        if (n == 2) return addr[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        return (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int n = nbytes(f3);
        logic [31:0] v, keep;
        if (n == 4) return word;
        v    = word >> (8 * lane_of(n, addr));
        keep = (32'h1 << (8 * n)) - 32'h1;
        v    = v & keep;
        if (!f3[2] && v[8*n-1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wdata);
        int n    = nbytes(f3);
        int lane = lane_of(n, addr);
        for (int j = 0; j < n; j++) word[8*(lane+j) +: 8] = wdata[8*j +: 8];
        return word;
    endfunction

    // One clock cycle: predict grants from the driven inputs, compare, then advance the model.
    task automatic cyc();
        bit ea, eb, ga, gb, mis;
        @(negedge clock);
        ea = a_valid && (!m_a_full || a_rsp_ready);
        eb = b_valid && (!m_b_full || b_rsp_ready);
        if (ea && eb) begin
            ga     = !m_rr_b;
            gb     = m_rr_b;
            m_rr_b = ga;
        end else begin
            ga = ea;
            gb = eb;
        end
        check_b("rnd_a_ready", a_ready, ga);
        check_b("rnd_b_ready", b_ready, gb);
        check_b("rnd_a_rsp_valid", a_rsp_valid, m_a_full);
        check_b("rnd_b_rsp_valid", b_rsp_valid, m_b_full);
        if (m_a_full) check_w("rnd_a_rsp_data", a_rsp_data, m_a_data);
        if (m_b_full) begin
            check_w("rnd_b_rsp_data", b_rsp_data, m_b_data);
            check_b("rnd_b_rsp_err", b_rsp_err, m_b_err);
        end
        if (ga) begin
            m_a_full = 1'b1;
            m_a_data = m_mem[a_addr[5:2]];
        end else if (a_rsp_ready) m_a_full = 1'b0;
        if (gb) begin
            mis      = MIS_EN && misaligned(b_funct3, b_addr);
            m_b_full = 1'b1;
            m_b_err  = mis;
            if (b_write) begin
                m_b_data = 32'h0;
                if (!mis) m_mem[b_addr[5:2]] = store_val(m_mem[b_addr[5:2]], b_funct3, b_addr, b_wdata);
            end else begin
                m_b_data = mis ? 32'h0 : load_val(m_mem[b_addr[5:2]], b_funct3, b_addr);
            end
        end else if (b_rsp_ready) m_b_full = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0; a_addr = 32'h0; a_rsp_ready = 1'b0;
        b_valid = 1'b0; b_write = 1'b0; b_funct3 = 3'b0; b_addr = 32'h0; b_wdata = 32'h0;
        b_rsp_ready = 1'b1;

        //            wr    f3    addr          wdata         exp_data                       exp_err
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,                         1'b0};
        vecs[1]  = '{1'b1, 3'd2, 32'h0000_0100, 32'h1122_3344, 32'h0,                         1'b0};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_0103, 32'h1234_56A5, 32'h0,                         1'b0};
        vecs[3]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'hFFFF_FFA5,                 1'b0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'h0000_00A5,                 1'b0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hA522_3344,                 1'b0};
        vecs[6]  = '{1'b1, 3'd1, 32'h0000_0102, 32'h7777_BEEF, 32'h0,                         1'b0};
        vecs[7]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'hFFFF_BEEF,                 1'b0};
        vecs[8]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,         32'h0000_BEEF,                 1'b0};
        vecs[9]  = '{1'b0, 3'd1, 32'h0000_0100, 32'h0,         32'h0000_3344,                 1'b0};
        vecs[10] = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,         32'h0000_0033,                 1'b0};
        vecs[11] = '{1'b1, 3'd2, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,                         1'b0};
        vecs[12] = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF,                 1'b0};
        vecs[13] = '{1'b0, 3'd2, 32'h0000_8008, 32'h0,         32'hDEAD_BEEF,                 1'b0};
        vecs[14] = '{1'b0, 3'd3, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF,                 1'b0};
        vecs[15] = '{1'b0, 3'd1, 32'h0000_0103, 32'h0,         MIS_EN ? 32'h0 : 32'hFFFF_BEEF, MIS_EN};
        vecs[16] = '{1'b1, 3'd2, 32'h0000_000A, 32'h1234_5678, 32'h0,                         MIS_EN};
        vecs[17] = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,         MIS_EN ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b0};
        vecs[18] = '{1'b0, 3'd4, 32'h0000_0010, 32'h0,         32'h0000_000D,                 1'b0};
        vecs[19] = '{1'b0, 3'd0, 32'h0000_0012, 32'h0,         32'hFFFF_FFFE,                 1'b0};

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_b("reset_a_rsp_valid", a_rsp_valid, 1'b0);
        check_b("reset_b_rsp_valid", b_rsp_valid, 1'b0);
        check_w("reset_a_rsp_data", a_rsp_data, 32'h0);
        check_w("reset_b_rsp_data", b_rsp_data, 32'h0);
        check_b("reset_b_rsp_err", b_rsp_err, 1'b0);
        @(posedge clock); #1;

        // vector table: one B access per cycle, back to back
        for (int i = 0; i < NV; i++) begin
            b_valid = 1'b1; b_write = vecs[i].wr; b_funct3 = vecs[i].f3;
            b_addr = vecs[i].addr; b_wdata = vecs[i].wdata;
            @(negedge clock);
            check_b($sformatf("tbl%0d_ready", i), b_ready, 1'b1);
            if (i > 0) begin
                check_b($sformatf("tbl%0d_rsp_valid", i-1), b_rsp_valid, 1'b1);
                check_w($sformatf("tbl%0d_data", i-1), b_rsp_data, vecs[i-1].exp_data);
                check_b($sformatf("tbl%0d_err", i-1), b_rsp_err, vecs[i-1].exp_err);
            end
            @(posedge clock); #1;
        end
        b_valid = 1'b0;
        @(negedge clock);
        check_w("tbl_last_data", b_rsp_data, vecs[NV-1].exp_data);
        check_b("tbl_last_err", b_rsp_err, vecs[NV-1].exp_err);
        @(posedge clock); #1;

        // A alone, then stalled response with B traffic in between
        a_valid = 1'b1; a_addr = 32'h10; a_rsp_ready = 1'b0;
        @(negedge clock);
        check_b("t1_a_ready", a_ready, 1'b1);
        check_b("t1_b_ready", b_ready, 1'b0);
        @(posedge clock); #1;
        a_addr = 32'h100;
        @(negedge clock);
        check_b("t1_a_rsp_valid", a_rsp_valid, 1'b1);
        check_w("t1_a_rsp_data", a_rsp_data, 32'hCAFE_F00D);
        check_b("t4_a_ready_stall", a_ready, 1'b0);
        @(posedge clock); #1;
        b_valid = 1'b1; b_write = 1'b0; b_funct3 = 3'd2; b_addr = 32'h100;
        @(negedge clock);
        check_b("t4_a_ready_stall2", a_ready, 1'b0);
        check_b("t4_b_ready", b_ready, 1'b1);
        @(posedge clock); #1;
        b_valid = 1'b0;
        @(negedge clock);
        check_w("t4_a_hold", a_rsp_data, 32'hCAFE_F00D);
        check_w("t4_b_data", b_rsp_data, 32'hBEEF_3344);
        check_b("t4_a_ready_stall3", a_ready, 1'b0);
        @(posedge clock); #1;
        a_rsp_ready = 1'b1;
        @(negedge clock);
        check_b("t4_a_ready_release", a_ready, 1'b1);
        check_w("t4_a_hold2", a_rsp_data, 32'hCAFE_F00D);
        @(posedge clock); #1;
        @(negedge clock);
        check_w("t4_a_new_data", a_rsp_data, 32'hBEEF_3344);
        @(posedge clock); #1;

        // both ports requesting every cycle: strict alternation starting with A
        a_addr = 32'h10; b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_b($sformatf("t2_a_ready%0d", k), a_ready, (k % 2) == 0);
            check_b($sformatf("t2_b_ready%0d", k), b_ready, (k % 2) == 1);
            if (k > 0) begin
                check_b($sformatf("t2_a_rsp_valid%0d", k), a_rsp_valid, ((k-1) % 2) == 0);
                check_b($sformatf("t2_b_rsp_valid%0d", k), b_rsp_valid, ((k-1) % 2) == 1);
                if (((k-1) % 2) == 0) check_w($sformatf("t2_a_data%0d", k), a_rsp_data, 32'hCAFE_F00D);
                else                  check_w($sformatf("t2_b_data%0d", k), b_rsp_data, 32'hBEEF_3344);
            end
            @(posedge clock); #1;
        end

        // async reset with a B response pending, then rr must be back at FIRST_B
        @(negedge clock);
        check_b("t6_tie_a_wins", a_ready, 1'b1);
        check_w("t6_b_data", b_rsp_data, 32'hBEEF_3344);
        @(posedge clock); #1;
        a_valid = 1'b0;
        @(negedge clock);
        check_b("t6_b_alone", b_ready, 1'b1);
        @(posedge clock); #1;
        b_valid = 1'b0; b_rsp_ready = 1'b0;
        @(negedge clock);
        check_b("t6_b_full", b_rsp_valid, 1'b1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_b("t6_b_rsp_valid_async", b_rsp_valid, 1'b0);
        check_w("t6_b_rsp_data_async", b_rsp_data, 32'h0);
        check_b("t6_a_rsp_valid_async", a_rsp_valid, 1'b0);
        check_b("t6_b_rsp_err_async", b_rsp_err, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        @(negedge clock);
        check_b("t6_rr_a_ready", a_ready, 1'b1);
        check_b("t6_rr_b_ready", b_ready, 1'b0);
        @(posedge clock); #1;

        // randomized traffic against the reference model
        a_valid = 1'b0; b_valid = 1'b0;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        m_a_full = 1'b0; m_b_full = 1'b0; m_rr_b = FIRST_B; m_b_err = 1'b0;
        m_a_data = 32'h0; m_b_data = 32'h0;
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
            b_valid = 1'b1; b_write = 1'b1; b_funct3 = 3'd2;
            b_addr = 32'(i * 4); b_wdata = $urandom();
            cyc();
        end
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] ia, ib;
            logic [1:0] oa, ob;
            ia = 4'($urandom_range(0, 15)); oa = 2'($urandom_range(0, 3));
            ib = 4'($urandom_range(0, 15)); ob = 2'($urandom_range(0, 3));
            a_valid     = $urandom_range(0, 3) != 0;
            a_rsp_ready = $urandom_range(0, 3) != 0;
            a_addr      = ($urandom() & 32'hFFFF_8000) | {26'h0, ia, oa};
            b_valid     = $urandom_range(0, 3) != 0;
            b_rsp_ready = $urandom_range(0, 3) != 0;
            b_write     = $urandom_range(0, 2) == 0;
            b_funct3    = 3'($urandom_range(0, 7));
            b_addr      = ($urandom() & 32'hFFFF_8000) | {26'h0, ib, ob};
            b_wdata     = $urandom();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
